// File: rtl/pyrite_pkg.sv
// ============================================================================
// pyrite_pkg: register map, identity constants and sequencer types shared by
// the Pyrite BPI flash controller.                              Rev 1.0
// ============================================================================
`default_nettype none

package pyrite_pkg;

    localparam logic [7:0] REG_TYPE     = 8'h00;
    localparam logic [7:0] REG_VERSION  = 8'h04;
    localparam logic [7:0] REG_NEXT_HDR = 8'h08;
    localparam logic [7:0] REG_FORMAT   = 8'h0C;
    localparam logic [7:0] REG_CTRL     = 8'h10;
    localparam logic [7:0] REG_ADDR     = 8'h14;
    localparam logic [7:0] REG_DATA     = 8'h18;
    localparam logic [7:0] REG_CMD      = 8'h1C;
    localparam logic [7:0] REG_TIMING   = 8'h20;
    localparam logic [7:0] REG_BOOT     = 8'h24;

    localparam logic [31:0] TYPE_ID    = 32'h0000C122;
    localparam logic [31:0] VERSION_ID = 32'h00002000;
    localparam logic [31:0] BOOT_KEY   = 32'hFEE1DEAD;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4
    } seq_state_e;

    // Field order matches the timing register layout {H, P, S}.
    typedef struct packed {
        logic [7:0] h;
        logic [7:0] p;
        logic [7:0] s;
    } timing_t;

    function automatic logic [7:0] strobe_len(input logic [7:0] p);
        return (p == 8'd0) ? 8'd0 : p - 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pyrite_bpi_seq_fsm.sv
// ============================================================================
// pyrite_bpi_seq_fsm: hardware-timed single flash access (ADDR/SETUP/STROBE/
// HOLD) with registered pin drive and read-data capture.       Rev 1.0
// ============================================================================
`default_nettype none

module pyrite_bpi_seq_fsm
    import pyrite_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              is_write_i,
    input  timing_t           timing_i,
    input  logic [DATA_W-1:0] dq_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              ce_n_o,
    output logic              oe_n_o,
    output logic              we_n_o,
    output logic              adv_n_o,
    output logic              dq_oe_o
);

    seq_state_e state_q;
    logic [7:0] cnt_q;
    timing_t    tim_q;
    logic       wr_q;

    // Final busy cycle; the top uses it to auto-increment on the exit edge.
    assign done_o = ((state_q == ST_STROBE) && (cnt_q == 8'd0) && (tim_q.h == 8'd0))
                 || ((state_q == ST_HOLD) && (cnt_q == 8'd0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            tim_q   <= '0;
            wr_q    <= 1'b0;
            busy_o  <= 1'b0;
            rdata_o <= '0;
            ce_n_o  <= 1'b1;
            oe_n_o  <= 1'b1;
            we_n_o  <= 1'b1;
            adv_n_o <= 1'b1;
            dq_oe_o <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_ADDR;
                        busy_o  <= 1'b1;
                        tim_q   <= timing_i;
                        wr_q    <= is_write_i;
                        ce_n_o  <= 1'b0;
                        adv_n_o <= 1'b0;
                        dq_oe_o <= is_write_i;
                    end
                end
                ST_ADDR: begin
                    adv_n_o <= 1'b1;
                    if (tim_q.s != 8'd0) begin
                        state_q <= ST_SETUP;
                        cnt_q   <= tim_q.s - 8'd1;
                    end else begin
                        state_q <= ST_STROBE;
                        cnt_q   <= strobe_len(tim_q.p);
                        oe_n_o  <= wr_q;
                        we_n_o  <= !wr_q;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= ST_STROBE;
                        cnt_q   <= strobe_len(tim_q.p);
                        oe_n_o  <= wr_q;
                        we_n_o  <= !wr_q;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_STROBE: begin
                    if (cnt_q == 8'd0) begin
                        if (!wr_q) begin
                            rdata_o <= dq_i;
                        end
                        oe_n_o <= 1'b1;
                        we_n_o <= 1'b1;
                        if (tim_q.h != 8'd0) begin
                            state_q <= ST_HOLD;
                            cnt_q   <= tim_q.h - 8'd1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_o  <= 1'b0;
                            ce_n_o  <= 1'b1;
                            dq_oe_o <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= ST_IDLE;
                        busy_o  <= 1'b0;
                        ce_n_o  <= 1'b1;
                        dq_oe_o <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/pyrite_bpi_flash_seq.sv
// ============================================================================
// pyrite_bpi_flash_seq: APB register file for the Pyrite BPI flash controller,
// manual bit-bang pins plus a hardware access sequencer.       Rev 1.0
// ============================================================================
`default_nettype none

module pyrite_bpi_flash_seq
    import pyrite_pkg::*;
#(
    parameter int          FLASH_DATA_W       = 16,
    parameter int          FLASH_ADDR_W       = 23,
    parameter int          FLASH_RGN_W        = 1,
    parameter int          FLASH_SEG_COUNT    = 2,
    parameter int          FLASH_SEG_DEFAULT  = 1,
    parameter int          FLASH_SEG_FALLBACK = 0,
    parameter logic [31:0] FLASH_SEG0_SIZE    = 32'h0,
    parameter logic [7:0]  NEXT_HDR           = 8'h00,
    parameter int          T_SETUP_DEFAULT    = 2,
    parameter int          T_STROBE_DEFAULT   = 8,
    parameter int          T_HOLD_DEFAULT     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              s_apb_paddr_i,
    input  logic                    s_apb_psel_i,
    input  logic                    s_apb_penable_i,
    input  logic                    s_apb_pwrite_i,
    input  logic [31:0]             s_apb_pwdata_i,
    input  logic [3:0]              s_apb_pstrb_i,
    output logic [31:0]             s_apb_prdata_o,
    output logic                    s_apb_pready_o,
    output logic                    s_apb_pslverr_o,
    output logic                    s_apb_pruser_o,
    output logic                    s_apb_pbuser_o,
    output logic                    fpga_boot,
    input  logic [FLASH_DATA_W-1:0] flash_dq_i,
    output logic [FLASH_DATA_W-1:0] flash_dq_o,
    output logic                    flash_dq_oe,
    output logic [FLASH_ADDR_W-1:0] flash_addr,
    output logic [FLASH_RGN_W-1:0]  flash_region,
    output logic                    flash_region_oe,
    output logic                    flash_ce_n,
    output logic                    flash_oe_n,
    output logic                    flash_we_n,
    output logic                    flash_adv_n
);

    localparam int FA_W = FLASH_ADDR_W + FLASH_RGN_W;

    logic                    pready_q;
    logic [31:0]             prdata_q;
    logic                    boot_q;
    logic                    ce_n_q, oe_n_q, we_n_q, adv_n_q;
    logic                    dq_oe_q, rgn_oe_q, mode_q;
    logic [FA_W-1:0]         fa_q, fa_d;
    logic [FLASH_DATA_W-1:0] dq_o_q;
    timing_t                 timing_q;
    logic                    autoinc_q;
    logic                    err_q, err_d;
    logic [31:0]             rd_d;

    logic                    seq_busy, seq_done;
    logic [FLASH_DATA_W-1:0] seq_rdata;
    logic                    seq_ce_n, seq_oe_n, seq_we_n, seq_adv_n, seq_dq_oe;

    logic [7:0] w_reg;
    logic       w_acc, w_wr, w_rd, w_cmd_wr, w_start_req, w_start, w_cfg_wr, w_err_set;
    logic       w_unused;

    assign w_reg       = {s_apb_paddr_i[7:2], 2'b00};
    assign w_acc       = s_apb_psel_i && s_apb_penable_i && !pready_q;
    assign w_wr        = w_acc && s_apb_pwrite_i;
    assign w_rd        = w_acc && !s_apb_pwrite_i;
    assign w_cmd_wr    = w_wr && (w_reg == REG_CMD);
    assign w_start_req = w_cmd_wr && (s_apb_pwdata_i[1:0] != 2'b00);
    assign w_start     = w_start_req && mode_q && !seq_busy
                      && (s_apb_pwdata_i[0] ^ s_apb_pwdata_i[1]);
    assign w_cfg_wr    = w_wr && ((w_reg == REG_CTRL) || (w_reg == REG_ADDR)
                      || (w_reg == REG_DATA) || (w_reg == REG_TIMING));
    // A refused start and any config write during a sequence both flag err.
    assign w_err_set   = (w_start_req && !w_start) || (w_cfg_wr && seq_busy);
    assign w_unused    = &{1'b0, s_apb_paddr_i[1:0], s_apb_pwdata_i};

    always_comb begin
        err_d = err_q;
        if (w_err_set) begin
            err_d = 1'b1;
        end else if (w_cmd_wr && s_apb_pwdata_i[17]) begin
            err_d = 1'b0;
        end
    end

    always_comb begin
        fa_d = fa_q;
        if (seq_done && autoinc_q) begin
            fa_d = fa_q + FA_W'(1);
        end else if (w_wr && !seq_busy && (w_reg == REG_ADDR)) begin
            fa_d = s_apb_pwdata_i[FA_W-1:0];
        end
    end

    always_comb begin
        rd_d = 32'h0;
        case (w_reg)
            REG_TYPE:     rd_d = TYPE_ID;
            REG_VERSION:  rd_d = VERSION_ID;
            REG_NEXT_HDR: rd_d = {24'h0, NEXT_HDR};
            REG_FORMAT:   rd_d = {FLASH_SEG0_SIZE[31:12], 4'(FLASH_SEG_FALLBACK),
                                  4'(FLASH_SEG_DEFAULT), 4'(FLASH_SEG_COUNT)};
            REG_CTRL:     rd_d = {7'h0, mode_q, 7'h0, rgn_oe_q, 7'h0, dq_oe_q,
                                  4'h0, adv_n_q, we_n_q, oe_n_q, ce_n_q};
            REG_ADDR:     rd_d = 32'(fa_q);
            REG_DATA:     rd_d = mode_q ? 32'(seq_rdata) : 32'(flash_dq_i);
            REG_CMD:      rd_d = {14'h0, err_q, seq_busy, 16'h0};
            REG_TIMING:   rd_d = {8'h0, timing_q};
            REG_BOOT:     rd_d = {31'h0, boot_q};
            default:      rd_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pready_q  <= 1'b0;
            prdata_q  <= 32'h0;
            boot_q    <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            adv_n_q   <= 1'b1;
            dq_oe_q   <= 1'b0;
            rgn_oe_q  <= 1'b0;
            mode_q    <= 1'b0;
            fa_q      <= '0;
            dq_o_q    <= '0;
            timing_q  <= {8'(T_HOLD_DEFAULT), 8'(T_STROBE_DEFAULT), 8'(T_SETUP_DEFAULT)};
            autoinc_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pready_q <= w_acc;
            fa_q     <= fa_d;
            err_q    <= err_d;
            if (w_rd) begin
                prdata_q <= rd_d;
            end
            if (w_start) begin
                autoinc_q <= s_apb_pwdata_i[8];
            end
            if (w_wr && (w_reg == REG_BOOT)) begin
                boot_q <= (s_apb_pwdata_i == BOOT_KEY);
            end
            if (w_wr && !seq_busy) begin
                case (w_reg)
                    REG_CTRL: begin
                        if (s_apb_pstrb_i[0]) begin
                            ce_n_q  <= s_apb_pwdata_i[0];
                            oe_n_q  <= s_apb_pwdata_i[1];
                            we_n_q  <= s_apb_pwdata_i[2];
                            adv_n_q <= s_apb_pwdata_i[3];
                        end
                        if (s_apb_pstrb_i[1]) dq_oe_q  <= s_apb_pwdata_i[8];
                        if (s_apb_pstrb_i[2]) rgn_oe_q <= s_apb_pwdata_i[16];
                        if (s_apb_pstrb_i[3]) mode_q   <= s_apb_pwdata_i[24];
                    end
                    REG_DATA:   dq_o_q   <= s_apb_pwdata_i[FLASH_DATA_W-1:0];
                    REG_TIMING: timing_q <= s_apb_pwdata_i[23:0];
                    default: ;
                endcase
            end
        end
    end

    pyrite_bpi_seq_fsm #(
        .DATA_W (FLASH_DATA_W)
    ) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .start_i    (w_start),
        .is_write_i (s_apb_pwdata_i[1]),
        .timing_i   (timing_q),
        .dq_i       (flash_dq_i),
        .busy_o     (seq_busy),
        .done_o     (seq_done),
        .rdata_o    (seq_rdata),
        .ce_n_o     (seq_ce_n),
        .oe_n_o     (seq_oe_n),
        .we_n_o     (seq_we_n),
        .adv_n_o    (seq_adv_n),
        .dq_oe_o    (seq_dq_oe)
    );

    assign s_apb_prdata_o  = prdata_q;
    assign s_apb_pready_o  = pready_q;
    assign s_apb_pslverr_o = 1'b0;
    assign s_apb_pruser_o  = 1'b0;
    assign s_apb_pbuser_o  = 1'b0;
    assign fpga_boot       = boot_q;
    assign flash_dq_o      = dq_o_q;
    assign flash_addr      = fa_q[FLASH_ADDR_W-1:0];
    assign flash_region    = fa_q[FA_W-1:FLASH_ADDR_W];
    assign flash_region_oe = rgn_oe_q;
    assign flash_ce_n      = mode_q ? seq_ce_n  : ce_n_q;
    assign flash_oe_n      = mode_q ? seq_oe_n  : oe_n_q;
    assign flash_we_n      = mode_q ? seq_we_n  : we_n_q;
    assign flash_adv_n     = mode_q ? seq_adv_n : adv_n_q;
    assign flash_dq_oe     = mode_q ? seq_dq_oe : dq_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_pyrite_bpi_flash_seq.sv
// ============================================================================
// tb_pyrite_bpi_flash_seq: directed self-checking bench for the Pyrite BPI
// flash controller.                                             Rev 1.0
// ============================================================================
`default_nettype none

module tb_pyrite_bpi_flash_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  paddr = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] prdata;
    logic        pready, pslverr, pruser, pbuser;
    logic        fpga_boot;
    logic [15:0] tb_dq = 16'h0000;
    logic [15:0] flash_dq_o;
    logic        flash_dq_oe;
    logic [22:0] flash_addr;
    logic [0:0]  flash_region;
    logic        flash_region_oe, flash_ce_n, flash_oe_n, flash_we_n, flash_adv_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pyrite_bpi_flash_seq dut (
        .clk             (clk),
        .rst             (rst),
        .s_apb_paddr_i   (paddr),
        .s_apb_psel_i    (psel),
        .s_apb_penable_i (penable),
        .s_apb_pwrite_i  (pwrite),
        .s_apb_pwdata_i  (pwdata),
        .s_apb_pstrb_i   (pstrb),
        .s_apb_prdata_o  (prdata),
        .s_apb_pready_o  (pready),
        .s_apb_pslverr_o (pslverr),
        .s_apb_pruser_o  (pruser),
        .s_apb_pbuser_o  (pbuser),
        .fpga_boot       (fpga_boot),
        .flash_dq_i      (tb_dq),
        .flash_dq_o      (flash_dq_o),
        .flash_dq_oe     (flash_dq_oe),
        .flash_addr      (flash_addr),
        .flash_region    (flash_region),
        .flash_region_oe (flash_region_oe),
        .flash_ce_n      (flash_ce_n),
        .flash_oe_n      (flash_oe_n),
        .flash_we_n      (flash_we_n),
        .flash_adv_n     (flash_adv_n)
    );

    task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd);
        int n;
        @(posedge clk); #1;
        paddr = a; pwdata = d; pstrb = s; pwrite = wr; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!pready && n < 16);
        if (!pready) begin
            checks++; failures++;
            $display("FAIL apb_timeout addr=%h pready=%b required=1", a, pready);
        end
        rd = prdata;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        apb_xfer(1'b1, a, d, s, dummy);
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        apb_xfer(1'b0, a, 32'h0, 4'h0, d);
    endtask

    // Issues a command and watches the pins for a fixed window.
    task automatic run_cmd(input logic [31:0] cmd, output logic b0, output int bc,
                           output int oc, output int wc, output logic [15:0] wdq,
                           output logic woe);
        apb_write(8'h1C, cmd, 4'hF);
        b0 = dut.seq_busy;
        bc = 0; oc = 0; wc = 0; wdq = 16'h0; woe = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (dut.seq_busy) bc++;
            if (!flash_oe_n) oc++;
            if (!flash_we_n) begin
                wc++; wdq = flash_dq_o; woe = flash_dq_oe;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic test_reset;
        logic [31:0] r;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", {28'h0, flash_adv_n, flash_we_n, flash_oe_n, flash_ce_n}, 32'hF);
        chk("rst_oe_boot_pready", {29'h0, flash_dq_oe, fpga_boot, pready}, 32'h0);
        chk("rst_addr_dq", {9'h0, flash_addr}, 32'h0);
        @(posedge clk); #1; rst = 1'b0;
        apb_read(8'h00, r); chk("rd_type", r, 32'h0000C122);
        apb_read(8'h04, r); chk("rd_version", r, 32'h00002000);
        apb_read(8'h08, r); chk("rd_next_hdr", r, 32'h0);
        apb_read(8'h0C, r); chk("rd_format", r, 32'h00000012);
        apb_read(8'h10, r); chk("rd_ctrl_rst", r, 32'h0000000F);
        apb_read(8'h20, r); chk("rd_timing_rst", r, 32'h00020802);
        apb_read(8'h28, r); chk("rd_unmapped", r, 32'h0);
        // Abort a long sequenced access with an async reset mid-cycle.
        apb_write(8'h10, 32'h01000000, 4'b1000);
        apb_write(8'h20, 32'h000808FF, 4'hF);
        apb_write(8'h1C, 32'h00000001, 4'hF);
        chk("abort_ce_active", {31'h0, flash_ce_n}, 32'h0);
        repeat (3) @(posedge clk);
        #4; rst = 1'b1;
        #1;
        chk("abort_strobes", {27'h0, flash_dq_oe, flash_adv_n, flash_we_n, flash_oe_n, flash_ce_n}, 32'hF);
        @(posedge clk); #1; rst = 1'b0;
        apb_read(8'h1C, r); chk("abort_cmd", r, 32'h0);
        apb_read(8'h20, r); chk("abort_timing", r, 32'h00020802);
        apb_read(8'h10, r); chk("abort_ctrl", r, 32'h0000000F);
    endtask

    task automatic test_seq_read;
        logic b0, woe; int bc, oc, wc; logic [15:0] wdq; logic [31:0] r;
        apb_write(8'h10, 32'h01000000, 4'b1000);
        apb_write(8'h20, 32'h00010402, 4'hF);
        apb_write(8'h14, 32'h00000010, 4'hF);
        tb_dq = 16'hA5C3;
        run_cmd(32'h1, b0, bc, oc, wc, wdq, woe);
        chk("rd_busy_start", {31'h0, b0}, 32'h1);
        chk("rd_busy_cycles", bc, 8);
        chk("rd_oe_cycles", oc, 4);
        chk("rd_we_cycles", wc, 0);
        tb_dq = 16'h5A5A;
        apb_read(8'h18, r); chk("rd_data_latched", r, 32'h0000A5C3);
        apb_read(8'h14, r); chk("rd_addr_kept", r, 32'h00000010);
        apb_read(8'h1C, r); chk("rd_status", r, 32'h0);
    endtask

    task automatic test_seq_write_autoinc;
        logic b0, woe; int bc, oc, wc; logic [15:0] wdq; logic [31:0] r;
        apb_write(8'h18, 32'h00001234, 4'hF);
        apb_write(8'h20, 32'h00000000, 4'hF);
        run_cmd(32'h102, b0, bc, oc, wc, wdq, woe);
        chk("wr_busy_cycles", bc, 2);
        chk("wr_we_cycles", wc, 1);
        chk("wr_oe_cycles", oc, 0);
        chk("wr_dq_at_we", {15'h0, woe, wdq}, 32'h00011234);
        chk("wr_dq_oe_after", {31'h0, flash_dq_oe}, 32'h0);
        apb_read(8'h14, r); chk("wr_addr_inc", r, 32'h00000011);
    endtask

    task automatic test_addr_wrap;
        logic b0, woe; int bc, oc, wc; logic [15:0] wdq; logic [31:0] r;
        apb_write(8'h14, 32'hFFFFFFFF, 4'hF);
        apb_read(8'h14, r); chk("wrap_addr_trunc", r, 32'h00FFFFFF);
        run_cmd(32'h101, b0, bc, oc, wc, wdq, woe);
        chk("wrap_busy_cycles", bc, 2);
        chk("wrap_oe_cycles", oc, 1);
        apb_read(8'h14, r); chk("wrap_addr_zero", r, 32'h0);
        chk("wrap_pins", {8'h0, flash_region, flash_addr}, 32'h0);
    endtask

    task automatic test_errors;
        logic b0, woe; int bc, oc, wc; logic [15:0] wdq; logic [31:0] r;
        run_cmd(32'h3, b0, bc, oc, wc, wdq, woe);
        chk("err_both_busy", bc, 0);
        chk("err_both_strobe", oc + wc, 0);
        apb_read(8'h1C, r); chk("err_both_flag", r, 32'h00020000);
        apb_write(8'h1C, 32'h00020000, 4'hF);
        apb_read(8'h1C, r); chk("err_w1c", r, 32'h0);
        apb_write(8'h1C, 32'h00020003, 4'hF);
        apb_read(8'h1C, r); chk("err_set_wins", r, 32'h00020000);
        apb_write(8'h1C, 32'h00020000, 4'hF);
        apb_write(8'h14, 32'h00000055, 4'hF);
        apb_write(8'h20, 32'h00001400, 4'hF);
        apb_write(8'h1C, 32'h00000001, 4'hF);
        apb_write(8'h14, 32'h00000077, 4'hF);
        apb_read(8'h1C, r); chk("err_busy_status", r, 32'h00030000);
        repeat (30) @(posedge clk);
        apb_read(8'h14, r); chk("err_addr_unchanged", r, 32'h00000055);
        apb_read(8'h1C, r); chk("err_after_busy", r, 32'h00020000);
        apb_write(8'h1C, 32'h00020000, 4'hF);
        apb_read(8'h1C, r); chk("err_w1c_2", r, 32'h0);
        apb_write(8'h10, 32'h00000000, 4'b1000);
        run_cmd(32'h1, b0, bc, oc, wc, wdq, woe);
        chk("err_manual_nostart", bc, 0);
        apb_read(8'h1C, r); chk("err_manual_flag", r, 32'h00020000);
        apb_write(8'h1C, 32'h00020000, 4'hF);
    endtask

    task automatic test_manual_boot;
        logic [31:0] r;
        apb_write(8'h10, 32'h0000010A, 4'hF);
        chk("man_strobes", {28'h0, flash_adv_n, flash_we_n, flash_oe_n, flash_ce_n}, 32'hA);
        chk("man_dq_oe", {31'h0, flash_dq_oe}, 32'h1);
        apb_write(8'h10, 32'h0000000F, 4'b0010);
        chk("man_pstrb_gate", {30'h0, flash_dq_oe, flash_ce_n}, 32'h0);
        tb_dq = 16'h5A5A;
        apb_read(8'h18, r); chk("man_live_data", r, 32'h00005A5A);
        apb_write(8'h24, 32'hFEE1DEAD, 4'hF);
        chk("boot_set", {31'h0, fpga_boot}, 32'h1);
        apb_write(8'h24, 32'h00000000, 4'hF);
        chk("boot_clear", {31'h0, fpga_boot}, 32'h0);
    endtask

    initial begin
        test_reset();
        test_seq_read();
        test_seq_write_autoinc();
        test_addr_wrap();
        test_errors();
        test_manual_boot();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
